// File: rtl/ip_rewrite_table_cfg_init.sv
// Configuration initiator for the IP rewrite lookup table.
// It takes one local set/clear request, sends it as a two-flit NoC message
// (header + body) to the lookup table controller, and then waits for the
// controller's acknowledgement or gives up after a timeout. Only one request
// is in flight at a time.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 256
`endif
`ifndef NOC_X_WIDTH
`define NOC_X_WIDTH 8
`endif
`ifndef NOC_Y_WIDTH
`define NOC_Y_WIDTH 8
`endif
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package ip_rewrite_cfg_pkg;
  localparam int NOC_W               = `NOC_DATA_WIDTH;
  localparam int X_W                 = `NOC_X_WIDTH;
  localparam int Y_W                 = `NOC_Y_WIDTH;
  localparam int ADDR_W              = `IP_ADDR_W;
  // Flow tuple: source IP, destination IP, source port, destination port.
  localparam int FLOW_LOOKUP_TUPLE_W = 96;
  localparam int MSG_LEN_W           = 8;
  localparam int MSG_TYPE_W          = 8;

  localparam logic [MSG_TYPE_W-1:0] LOOKUP_TABLE_WR   = 8'h0C;
  localparam logic [MSG_TYPE_W-1:0] LOOKUP_TABLE_RESP = 8'h0D;

  // Header is MSB-aligned: dst_x, dst_y, src_x, src_y, msg_len, msg_type.
  localparam int HDR_W        = 2 * X_W + 2 * Y_W + MSG_LEN_W + MSG_TYPE_W;
  localparam int SRC_X_LSB    = NOC_W - 2 * X_W - Y_W;
  localparam int SRC_Y_LSB    = NOC_W - 2 * X_W - 2 * Y_W;
  localparam int MSG_TYPE_LSB = NOC_W - HDR_W;

  // Body is MSB-aligned: {set, tuple, addr}.
  localparam int BODY_W = 1 + FLOW_LOOKUP_TUPLE_W + ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BODY,
    WAIT_RESP,
    DONE
  } state_e;
endpackage

module ip_rewrite_table_cfg_init
  import ip_rewrite_cfg_pkg::*;
#(
  parameter int SRC_X          = -1,
  parameter int SRC_Y          = -1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic                           req_val,
  output logic                           req_rdy,
  input  logic                           req_set,
  input  logic [FLOW_LOOKUP_TUPLE_W-1:0] req_tuple,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [X_W-1:0]                 req_dst_x,
  input  logic [Y_W-1:0]                 req_dst_y,

  output logic                           resp_val,
  output logic                           resp_ok,
  input  logic                           resp_rdy,

  output logic                           cfg_out_noc_val,
  output logic [NOC_W-1:0]               cfg_out_noc_data,
  input  logic                           noc_cfg_out_rdy,

  input  logic                           noc_cfg_in_val,
  input  logic [NOC_W-1:0]               noc_cfg_in_data,
  output logic                           cfg_in_noc_rdy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [X_W-1:0]   SRC_X_F  = X_W'(SRC_X);
  localparam logic [Y_W-1:0]   SRC_Y_F  = Y_W'(SRC_Y);

  state_e                         state;
  logic [CNT_W-1:0]               cnt;
  logic                           set_q;
  logic [FLOW_LOOKUP_TUPLE_W-1:0] tuple_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [X_W-1:0]                 dst_x_q;
  logic [Y_W-1:0]                 dst_y_q;

  logic [X_W-1:0]        rsp_src_x;
  logic [Y_W-1:0]        rsp_src_y;
  logic [MSG_TYPE_W-1:0] rsp_type;
  logic                  match;
  logic                  unused_in_bits;

  function automatic logic [NOC_W-1:0] hdr_flit(input logic [X_W-1:0] dx,
                                                input logic [Y_W-1:0] dy);
    return {dx, dy, SRC_X_F, SRC_Y_F, MSG_LEN_W'(1), LOOKUP_TABLE_WR,
            {(NOC_W - HDR_W){1'b0}}};
  endfunction

  // Responses are always accepted; anything not matching is simply dropped.
  assign cfg_in_noc_rdy = 1'b1;

  // A response matches when it is an ack from the tile the request went to.
  assign rsp_src_x = noc_cfg_in_data[SRC_X_LSB +: X_W];
  assign rsp_src_y = noc_cfg_in_data[SRC_Y_LSB +: Y_W];
  assign rsp_type  = noc_cfg_in_data[MSG_TYPE_LSB +: MSG_TYPE_W];
  assign match     = noc_cfg_in_val && (rsp_type == LOOKUP_TABLE_RESP) &&
                     (rsp_src_x == dst_x_q) && (rsp_src_y == dst_y_q);

  // Destination, length and payload bits of a response carry nothing we need.
  assign unused_in_bits = ^{noc_cfg_in_data[NOC_W-1 -: X_W + Y_W],
                            noc_cfg_in_data[MSG_TYPE_LSB + MSG_TYPE_W +: MSG_LEN_W],
                            noc_cfg_in_data[MSG_TYPE_LSB-1:0]};

  // Request FSM; every output is registered and changes only on a state move.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and updates together at the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      set_q            <= 1'b0;
      tuple_q          <= '0;
      addr_q           <= '0;
      dst_x_q          <= '0;
      dst_y_q          <= '0;
      req_rdy          <= 1'b1;
      resp_val         <= 1'b0;
      resp_ok          <= 1'b0;
      cfg_out_noc_val  <= 1'b0;
      cfg_out_noc_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_rdy is high exactly in IDLE, so req_val alone is the handshake.
          if (req_val) begin
            set_q            <= req_set;
            tuple_q          <= req_tuple;
            addr_q           <= req_addr;
            dst_x_q          <= req_dst_x;
            dst_y_q          <= req_dst_y;
            req_rdy          <= 1'b0;
            cfg_out_noc_val  <= 1'b1;
            cfg_out_noc_data <= hdr_flit(req_dst_x, req_dst_y);
            state            <= HDR;
          end
        end
        HDR: begin
          if (noc_cfg_out_rdy) begin
            cfg_out_noc_data <= {set_q, tuple_q, addr_q, {(NOC_W - BODY_W){1'b0}}};
            state            <= BODY;
          end
        end
        BODY: begin
          if (noc_cfg_out_rdy) begin
            cfg_out_noc_val  <= 1'b0;
            cfg_out_noc_data <= '0;
            cnt              <= '0;
            state            <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A match on the last counted cycle still wins over the timeout.
          if (match) begin
            resp_val <= 1'b1;
            resp_ok  <= 1'b1;
            state    <= DONE;
          end else if (cnt == CNT_LAST) begin
            resp_val <= 1'b1;
            resp_ok  <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (resp_rdy) begin
            resp_val <= 1'b0;
            resp_ok  <= 1'b0;
            req_rdy  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_rewrite_table_cfg_init.sv
// Bench for ip_rewrite_table_cfg_init: a table of directed transactions,
// a reset-in-flight sequence, and randomized transactions scored against a
// transaction-level model of the ack/timeout rule.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 256
`endif
`ifndef NOC_X_WIDTH
`define NOC_X_WIDTH 8
`endif
`ifndef NOC_Y_WIDTH
`define NOC_Y_WIDTH 8
`endif
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

module tb_ip_rewrite_table_cfg_init;
  localparam int W  = `NOC_DATA_WIDTH;
  localparam int XW = `NOC_X_WIDTH;
  localparam int YW = `NOC_Y_WIDTH;
  localparam int AW = `IP_ADDR_W;
  localparam int TW = 96;
  localparam int TO = 16;
  localparam int SX = 5;
  localparam int SY = 6;
  localparam logic [7:0] T_WR   = 8'h0C;
  localparam logic [7:0] T_RESP = 8'h0D;

  logic          clk;
  logic          rst;
  logic          req_val, req_rdy, req_set;
  logic [TW-1:0] req_tuple;
  logic [AW-1:0] req_addr;
  logic [XW-1:0] req_dst_x;
  logic [YW-1:0] req_dst_y;
  logic          resp_val, resp_ok, resp_rdy;
  logic          cfg_out_noc_val, noc_cfg_out_rdy;
  logic [W-1:0]  cfg_out_noc_data;
  logic          noc_cfg_in_val, cfg_in_noc_rdy;
  logic [W-1:0]  noc_cfg_in_data;

  ip_rewrite_table_cfg_init #(
    .SRC_X(SX), .SRC_Y(SY), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_set(req_set),
    .req_tuple(req_tuple), .req_addr(req_addr),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y),
    .resp_val(resp_val), .resp_ok(resp_ok), .resp_rdy(resp_rdy),
    .cfg_out_noc_val(cfg_out_noc_val), .cfg_out_noc_data(cfg_out_noc_data),
    .noc_cfg_out_rdy(noc_cfg_out_rdy),
    .noc_cfg_in_val(noc_cfg_in_val), .noc_cfg_in_data(noc_cfg_in_data),
    .cfg_in_noc_rdy(cfg_in_noc_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_flits = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (cfg_out_noc_val && noc_cfg_out_rdy) n_flits++;
  end

  typedef struct {
    logic          set;
    logic [TW-1:0] tuple;
    logic [AW-1:0] addr;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    int            hs;          // HDR stall cycles
    int            bs;          // BODY stall cycles
    int            resp_at;     // WAIT cycle of matching response, <0 = none
    int            decoy_at;    // WAIT cycle of non-matching response, <0 = none
    int            decoy_kind;  // 0 wrong x, 1 wrong y, 2 wrong msg type
    int            hold;        // cycles resp_rdy is held low
    logic          exp_ok;
    int            exp_wait;    // WAIT cycles until DONE
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_hdr(input logic [XW-1:0] dx, input logic [YW-1:0] dy);
    logic [W-1:0] f;
    f = '0;
    f = f | (W'(dx) << (W - XW));
    f = f | (W'(dy) << (W - XW - YW));
    f = f | (W'(SX) << (W - 2 * XW - YW));
    f = f | (W'(SY) << (W - 2 * XW - 2 * YW));
    f = f | (W'(1) << (W - 2 * XW - 2 * YW - 8));
    f = f | (W'(T_WR) << (W - 2 * XW - 2 * YW - 16));
    return f;
  endfunction

  function automatic logic [W-1:0] exp_body(input logic s, input logic [TW-1:0] tp,
                                            input logic [AW-1:0] a);
    return W'({s, tp, a}) << (W - 1 - TW - AW);
  endfunction

  // Response flit from (sx,sy) with random destination and payload junk.
  function automatic logic [W-1:0] resp_flit(input logic [XW-1:0] sx, input logic [YW-1:0] sy,
                                             input logic [7:0] typ);
    logic [W-1:0] f;
    f = W'($urandom);
    f = f | (W'($urandom_range(0, 255)) << (W - XW));
    f = f | (W'(sx) << (W - 2 * XW - YW));
    f = f | (W'(sy) << (W - 2 * XW - 2 * YW));
    f = f | (W'(typ) << (W - 2 * XW - 2 * YW - 16));
    return f;
  endfunction

  // Transaction-level rule: first matching ack inside the window wins,
  // otherwise the request times out after TO waiting cycles.
  task automatic model(input int resp_at, output logic ok, output int wait_c);
    ok     = (resp_at >= 0) && (resp_at < TO);
    wait_c = ok ? resp_at + 1 : TO;
  endtask

  task automatic issue(input logic s, input logic [TW-1:0] tp, input logic [AW-1:0] a,
                       input logic [XW-1:0] dx, input logic [YW-1:0] dy, output int t0);
    check("req_rdy_idle", W'(req_rdy), W'(1));
    req_val = 1'b1; req_set = s; req_tuple = tp; req_addr = a;
    req_dst_x = dx; req_dst_y = dy;
    step();
    t0 = cyc;
    // Scramble the request bus so only registered values can produce flits.
    req_val = 1'b0; req_set = ~s; req_tuple = {$urandom, $urandom, $urandom};
    req_addr = $urandom; req_dst_x = ~dx; req_dst_y = ~dy;
    check("hdr_val", W'(cfg_out_noc_val), W'(1));
    check("req_rdy_busy", W'(req_rdy), W'(0));
  endtask

  task automatic push_flits(input logic [W-1:0] hdr, input logic [W-1:0] body,
                            input int hs, input int bs);
    int f0;
    f0 = n_flits;
    check("hdr_data", cfg_out_noc_data, hdr);
    noc_cfg_out_rdy = 1'b0;
    repeat (hs) begin
      step();
      check("hdr_hold_val", W'(cfg_out_noc_val), W'(1));
      check("hdr_hold_data", cfg_out_noc_data, hdr);
    end
    noc_cfg_out_rdy = 1'b1;
    step();
    check("body_val", W'(cfg_out_noc_val), W'(1));
    check("body_data", cfg_out_noc_data, body);
    noc_cfg_out_rdy = 1'b0;
    repeat (bs) begin
      step();
      check("body_hold_val", W'(cfg_out_noc_val), W'(1));
      check("body_hold_data", cfg_out_noc_data, body);
    end
    noc_cfg_out_rdy = 1'b1;
    step();
    check("val_after_body", W'(cfg_out_noc_val), W'(0));
    check("flit_count", W'(n_flits - f0), W'(2));
  endtask

  task automatic wait_resp(input logic [XW-1:0] dx, input logic [YW-1:0] dy,
                           input int resp_at, input int decoy_at, input int kind,
                           input logic exp_ok, input int exp_wait, input int lat_exp,
                           input int t0);
    check("in_rdy", W'(cfg_in_noc_rdy), W'(1));
    for (int k = 0; k < exp_wait; k++) begin
      noc_cfg_in_val = 1'b0;
      if (k == resp_at) begin
        noc_cfg_in_val  = 1'b1;
        noc_cfg_in_data = resp_flit(dx, dy, T_RESP);
      end else if (k == decoy_at) begin
        noc_cfg_in_val = 1'b1;
        case (kind)
          0:       noc_cfg_in_data = resp_flit(dx + 1'b1, dy, T_RESP);
          1:       noc_cfg_in_data = resp_flit(dx, dy + 1'b1, T_RESP);
          default: noc_cfg_in_data = resp_flit(dx, dy, T_WR);
        endcase
      end
      step();
      noc_cfg_in_val = 1'b0;
      if (k < exp_wait - 1) check("no_early_resp", W'(resp_val), W'(0));
    end
    check("resp_val", W'(resp_val), W'(1));
    check("resp_ok", W'(resp_ok), W'(exp_ok));
    check("latency", W'(cyc - t0 + 1), W'(lat_exp));
  endtask

  task automatic finish_resp(input int hold, input logic exp_ok);
    resp_rdy = 1'b0;
    repeat (hold) begin
      step();
      check("hold_resp_val", W'(resp_val), W'(1));
      check("hold_resp_ok", W'(resp_ok), W'(exp_ok));
      check("hold_req_rdy", W'(req_rdy), W'(0));
    end
    resp_rdy = 1'b1;
    step();
    check("resp_val_clear", W'(resp_val), W'(0));
    check("req_rdy_back", W'(req_rdy), W'(1));
  endtask

  // A late ack to an already-finished request must not produce a response.
  task automatic late_drop(input logic [XW-1:0] dx, input logic [YW-1:0] dy);
    noc_cfg_in_val  = 1'b1;
    noc_cfg_in_data = resp_flit(dx, dy, T_RESP);
    step();
    noc_cfg_in_val = 1'b0;
    step();
    check("late_no_resp", W'(resp_val), W'(0));
    check("late_req_rdy", W'(req_rdy), W'(1));
  endtask

  task automatic do_txn(input vec_t v);
    int t0;
    issue(v.set, v.tuple, v.addr, v.dx, v.dy, t0);
    push_flits(exp_hdr(v.dx, v.dy), exp_body(v.set, v.tuple, v.addr), v.hs, v.bs);
    wait_resp(v.dx, v.dy, v.resp_at, v.decoy_at, v.decoy_kind, v.exp_ok, v.exp_wait,
              v.hs + v.bs + 3 + v.exp_wait, t0);
    finish_resp(v.hold, v.exp_ok);
    late_drop(v.dx, v.dy);
  endtask

  initial begin
    int   t0;
    vec_t v;

    // set, tuple, addr, dx, dy, hs, bs, resp_at, decoy_at, kind, hold, ok, wait
    vecs[0] = '{1'b1, 96'h0A000001_C0A80001_1F901234, 32'h0A000001, 8'd2, 8'd1,
                0, 0, 0, -1, 0, 0, 1'b1, 1};           // basic set, minimum latency 4
    vecs[1] = '{1'b1, 96'h11223344_55667788_99AABBCC, 32'hC0A80101, 8'd2, 8'd1,
                5, 3, 2, -1, 0, 0, 1'b1, 3};           // output backpressure
    vecs[2] = '{1'b0, 96'hDEADBEEF_01020304_05060708, 32'h7F000001, 8'd2, 8'd1,
                0, 0, -1, -1, 0, 0, 1'b0, 16};         // timeout
    vecs[3] = '{1'b1, 96'hFFFFFFFF_00000000_A5A5A5A5, 32'h0A0000FE, 8'd2, 8'd1,
                0, 0, 4, 1, 0, 0, 1'b1, 5};            // (3,1) decoy dropped
    vecs[4] = '{1'b1, 96'h01234567_89ABCDEF_02468ACE, 32'h08080808, 8'd2, 8'd1,
                1, 0, 15, 7, 2, 4, 1'b1, 16};          // ack on final timeout cycle

    rst = 1'b0; req_val = 1'b0; req_set = 1'b0; req_tuple = '0; req_addr = '0;
    req_dst_x = '0; req_dst_y = '0; resp_rdy = 1'b1; noc_cfg_out_rdy = 1'b1;
    noc_cfg_in_val = 1'b0; noc_cfg_in_data = '0;
    step();
    step();
    check("rst_req_rdy", W'(req_rdy), W'(1));
    check("rst_resp_val", W'(resp_val), W'(0));
    check("rst_resp_ok", W'(resp_ok), W'(0));
    check("rst_out_val", W'(cfg_out_noc_val), W'(0));
    check("rst_out_data", cfg_out_noc_data, W'(0));
    check("rst_in_rdy", W'(cfg_in_noc_rdy), W'(1));
    rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // Reset while waiting for an ack, then a late ack, then a clear request.
    issue(1'b1, 96'hCAFEF00D_0000_1111_2222_3333, 32'h0A000002, 8'd2, 8'd1, t0);
    push_flits(exp_hdr(8'd2, 8'd1),
               exp_body(1'b1, 96'hCAFEF00D_0000_1111_2222_3333, 32'h0A000002), 0, 0);
    repeat (3) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_req_rdy", W'(req_rdy), W'(1));
    check("mid_rst_resp_val", W'(resp_val), W'(0));
    check("mid_rst_out_val", W'(cfg_out_noc_val), W'(0));
    check("mid_rst_out_data", cfg_out_noc_data, W'(0));
    noc_cfg_in_val  = 1'b1;
    noc_cfg_in_data = resp_flit(8'd2, 8'd1, T_RESP);
    step();
    noc_cfg_in_val = 1'b0;
    repeat (2) begin
      step();
      check("mid_rst_no_resp", W'(resp_val), W'(0));
    end
    v = '{1'b0, 96'h0BADF00D_12345678_9ABCDEF0, 32'h0A000002, 8'd2, 8'd1,
          0, 0, 1, -1, 0, 0, 1'b1, 2};
    do_txn(v);

    // Randomized transactions scored by the model.
    for (int i = 0; i < 20; i++) begin
      v.set        = 1'($urandom_range(0, 1));
      v.tuple      = {$urandom, $urandom, $urandom};
      v.addr       = $urandom;
      v.dx         = XW'($urandom_range(0, 7));
      v.dy         = YW'($urandom_range(0, 7));
      v.hs         = $urandom_range(0, 3);
      v.bs         = $urandom_range(0, 3);
      v.resp_at    = int'($urandom_range(0, 20)) - 2;
      v.decoy_at   = $urandom_range(0, TO - 1);
      if (v.decoy_at == v.resp_at) v.decoy_at = -1;
      v.decoy_kind = $urandom_range(0, 2);
      v.hold       = $urandom_range(0, 2);
      model(v.resp_at, v.exp_ok, v.exp_wait);
      do_txn(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ip_rewrite_table_cfg_init.md
IP_REWRITE_TABLE_CFG_INIT -- requirements
Module: ip_rewrite_table_cfg_init

Interface
REQ-001 SHALL have parameter SRC_X, default -1, NoC X coordinate of this tile, placed in the header source field.
REQ-002 SHALL have parameter SRC_Y, default -1, NoC Y coordinate of this tile, placed in the header source field.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the number of WAIT_RESP cycles before the request is abandoned.
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port rst, input, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have ports req_val (in, 1) and req_rdy (out, 1), the local request handshake.
REQ-007 SHALL have ports req_set (in, 1), req_tuple (in, FLOW_LOOKUP_TUPLE_W), req_addr (in, `IP_ADDR_W), req_dst_x (in, `NOC_X_WIDTH) and req_dst_y (in, `NOC_Y_WIDTH), giving the entry to set or clear and the rewrite tile address.
REQ-008 SHALL have ports resp_val (out, 1), resp_ok (out, 1; 1 = acked, 0 = timeout) and resp_rdy (in, 1), the completion handshake.
REQ-009 SHALL have ports cfg_out_noc_val (out, 1), cfg_out_noc_data (out, `NOC_DATA_WIDTH) and noc_cfg_out_rdy (in, 1), the request flits to the lookup table controller.
REQ-010 SHALL have ports noc_cfg_in_val (in, 1), noc_cfg_in_data (in, `NOC_DATA_WIDTH) and cfg_in_noc_rdy (out, 1), the response flits from the lookup table controller.

Function
REQ-011 SHALL implement the FSM states IDLE, HDR, BODY, WAIT_RESP and DONE.
REQ-012 SHALL assert req_rdy only in IDLE; on req_val&req_rdy it SHALL register all req_* fields and go to HDR.
REQ-013 SHALL, in HDR, drive the standard NoC header: dst = registered x/y, src = SRC_X/SRC_Y, msg_len = 1, msg_type = LOOKUP_TABLE_WR, with all other bits 0.
REQ-014 SHALL, in BODY, drive a flit containing {set, tuple, addr} MSB-aligned, with the remainder 0.
REQ-015 SHALL assert cfg_out_noc_val only in HDR and BODY; a state SHALL advance only on val&rdy, and data SHALL hold stable while val=1 and rdy=0.
REQ-016 SHALL, on entry to WAIT_RESP, clear the timeout counter, then increment it by 1 each cycle without a matching response.
REQ-017 SHALL treat a flit as a match when msg_type = LOOKUP_TABLE_RESP and its src x/y equal the registered dst x/y; a match SHALL set ok=1 and go to DONE.
REQ-018 SHALL go to DONE with ok=0 when the counter reaches TIMEOUT_CYCLES-1 without a match; a match arriving in that same cycle SHALL win (ok=1).
REQ-019 SHALL hold cfg_in_noc_rdy = 1 in every state; non-matching flits, and any flit outside WAIT_RESP, SHALL be consumed and dropped (no NoC backpressure).
REQ-020 SHALL assert resp_val with resp_ok in DONE; on resp_val&resp_rdy it SHALL return to IDLE, so a new request is accepted no earlier than the next cycle.
REQ-021 SHALL allow exactly one outstanding request.
REQ-022 SHALL give a minimum latency, from request accept to resp_val, of 4 cycles (HDR, BODY, one WAIT_RESP match cycle, DONE), with rdy always high and the response arriving on the first WAIT_RESP cycle.
REQ-023 SHALL set the counter width to $clog2(TIMEOUT_CYCLES)+1 bits; the counter SHALL never wrap.

Reset
REQ-024 SHALL, while rst=0 at a clock edge, set state=IDLE, counter=0 and all registered fields to 0.
REQ-025 SHALL, after reset, drive req_rdy=1, resp_val=0, resp_ok=0, cfg_out_noc_val=0, cfg_out_noc_data=0 and cfg_in_noc_rdy=1.
REQ-026 SHALL abandon any in-flight request on reset without emitting a response; a response flit that arrives late SHALL be dropped per REQ-019.

Verification
REQ-027 SHALL cover basic set: req set=1, addr=0x0A000001, dst=(2,1), rdy always 1; expect header with dst (2,1), msg_len 1, then body; inject RESP from (2,1) on the next cycle; expect resp_val, resp_ok=1, 4 cycles after accept.
REQ-028 SHALL cover backpressure: noc_cfg_out_rdy=0 for 5 cycles during HDR and 3 cycles during BODY; expect val held and data unchanged, and exactly 2 flits transferred.
REQ-029 SHALL cover timeout: TIMEOUT_CYCLES=16 with no response; expect resp_ok=0 exactly 16 cycles after entering WAIT_RESP; a RESP injected afterward is dropped with no second resp_val.
REQ-030 SHALL cover the mismatch filter: RESP from (3,1) while waiting on (2,1) is dropped and waiting continues; a later RESP from (2,1) gives ok=1.
REQ-031 SHALL cover simultaneous events: a matching RESP on the final timeout cycle gives ok=1; holding resp_rdy=0 for 4 cycles keeps resp_val=1 and req_rdy=0.
REQ-032 SHALL cover reset mid-WAIT_RESP: rst=0 for 1 cycle; expect IDLE, req_rdy=1 and no resp_val; a clear request (set=0) then completes normally.
